// File: rtl/fpu_pkg.sv
// Shared FP-issue constants: op codes, FPU idle code, latencies, timeout.
package fpu_pkg;

    localparam logic [3:0] OP_FADD   = 4'd0;
    localparam logic [3:0] OP_FSUB   = 4'd1;
    localparam logic [3:0] OP_FMUL   = 4'd2;
    localparam logic [3:0] OP_FDIV   = 4'd3;
    localparam logic [3:0] OP_FSQRT  = 4'd4;
    localparam logic [3:0] OP_FSGNJ  = 4'd5;
    localparam logic [3:0] OP_FSGNJN = 4'd6;
    localparam logic [3:0] OP_FSGNJX = 4'd7;
    localparam logic [3:0] OP_FEQ    = 4'd8;
    localparam logic [3:0] OP_FLE    = 4'd9;
    localparam logic [3:0] OP_FLT    = 4'd10;
    localparam logic [3:0] OP_FCVTWS = 4'd11;
    localparam logic [3:0] OP_FCVTSW = 4'd12;

    // Highest legal op code; 13..15 are rejected with an error response.
    localparam logic [3:0] OP_LAST   = OP_FCVTSW;

    // Idle code: FPU reports fin=1 and stays in its start state.
    localparam logic [3:0] OP_IDLE   = 4'hF;

    // Accept-to-resp_valid latencies in cycles, as seen by the core.
    localparam int LAT_SIMPLE = 2;
    localparam int LAT_ADDMUL = 5;
    localparam int LAT_SQRT   = 10;
    localparam int LAT_DIV    = 12;

    // ISSUE cycles allowed without fpu_fin before giving up.
    localparam logic [3:0] TIMEOUT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

    // Comparisons and float-to-int conversion write the integer file.
    function automatic logic is_int_dest(input logic [3:0] op);
        return (op >= OP_FEQ) && (op <= OP_FCVTWS);
    endfunction

endpackage

// File: rtl/fpu_issue.sv
// Issue stage between the core and an iterative FPU: registers one request,
// holds it on the FPU port until fin (or timeout), then holds the result
// for writeback.
//
// Handshakes: a request moves when req_valid && req_ready at a rising edge;
// a response moves when resp_valid && resp_ready at a rising edge. A new
// request may be accepted on the same edge that consumes the response.
module fpu_issue
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_rd,
    output logic        resp_int,
    output logic        resp_err,
    output logic [31:0] fpu_src0,
    output logic [31:0] fpu_src1,
    output logic [3:0]  fpu_op,
    input  logic [31:0] fpu_result,
    input  logic        fpu_fin
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [31:0] src0_q, src1_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q, res_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        int_q, int_d;
    logic        err_q, err_d;
    logic        accept;
    logic        load_req;
    logic        load_resp;

    // Ready in IDLE, or in RESP when the held result is leaving this cycle.
    assign req_ready = !rst && ((state_q == ST_IDLE) ||
                                ((state_q == ST_RESP) && resp_ready));
    assign accept    = req_valid && req_ready;

    assign resp_valid  = (state_q == ST_RESP);
    assign resp_result = res_q;
    assign resp_rd     = resp_rd_q;
    assign resp_int    = int_q;
    assign resp_err    = err_q;

    assign fpu_op   = (state_q == ST_ISSUE) ? op_q : OP_IDLE;
    assign fpu_src0 = src0_q;
    assign fpu_src1 = src1_q;

    // Next state, wait counter and register load enables.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_req  = 1'b0;
        load_resp = 1'b0;
        res_d     = 32'd0;
        resp_rd_d = rd_q;
        int_d     = is_int_dest(op_q);
        err_d     = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                cnt_d = cnt_q + 4'd1;
                if (fpu_fin) begin
                    state_d   = ST_RESP;
                    load_resp = 1'b1;
                    res_d     = fpu_result;
                end else if (cnt_d == TIMEOUT) begin
                    state_d   = ST_RESP;
                    load_resp = 1'b1;
                    err_d     = 1'b1;
                end
            end
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (is_legal(req_op)) begin
                        state_d  = ST_ISSUE;
                        load_req = 1'b1;
                        cnt_d    = 4'd0;
                    end else begin
                        // Illegal op: answer immediately, FPU never sees it.
                        state_d   = ST_RESP;
                        load_resp = 1'b1;
                        err_d     = 1'b1;
                        resp_rd_d = req_rd;
                        int_d     = 1'b0;
                    end
                end else if ((state_q == ST_RESP) && resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, request and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_q      <= 4'd0;
            src0_q    <= 32'd0;
            src1_q    <= 32'd0;
            rd_q      <= 5'd0;
            res_q     <= 32'd0;
            resp_rd_q <= 5'd0;
            int_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_req) begin
                op_q   <= req_op;
                src0_q <= req_src0;
                src1_q <= req_src1;
                rd_q   <= req_rd;
            end
            if (load_resp) begin
                res_q     <= res_d;
                resp_rd_q <= resp_rd_d;
                int_q     <= int_d;
                err_q     <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: stub FPU with per-op latency, directed table,
// hand-written corner sequences, then randomized traffic against a model.
module tb_fpu_issue;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_src0;
    logic [31:0] req_src1;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_rd;
    logic        resp_int;
    logic        resp_err;
    logic [31:0] fpu_src0;
    logic [31:0] fpu_src1;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        fpu_fin;

    int n_chk  = 0;
    int n_fail = 0;

    fpu_issue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src0(req_src0), .req_src1(req_src1), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_rd(resp_rd),
        .resp_int(resp_int), .resp_err(resp_err),
        .fpu_src0(fpu_src0), .fpu_src1(fpu_src1), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .fpu_fin(fpu_fin)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stub FPU ----------------
    // fin comes after a fixed number of ISSUE cycles per op; result is
    // scrambled while fin is low so an early capture is visible.
    logic [3:0]  cur_op;
    logic [31:0] cur_a, cur_b, ans;
    bit          never_fin;
    int          fpu_cyc;

    function automatic int fpu_need(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2: return 4;
            4'd3:             return 11;
            4'd4:             return 9;
            default:          return 1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)                               fpu_cyc <= 0;
        else if (fpu_op != 4'hF && !fpu_fin)   fpu_cyc <= fpu_cyc + 1;
        else                                   fpu_cyc <= 0;
    end

    assign fpu_fin    = (fpu_op == 4'hF) || (!never_fin && (fpu_cyc + 1 >= fpu_need(fpu_op)));
    assign fpu_result = fpu_fin ? ans : ~ans;

    // While the FPU is busy the operands must match the accepted request
    // and no new request may be taken.
    always @(negedge clk) begin
        if (!rst && fpu_op !== 4'hF) begin
            chk("fpu_op_hold", {28'd0, fpu_op}, {28'd0, cur_op});
            chk("fpu_src0_hold", fpu_src0, cur_a);
            chk("fpu_src1_hold", fpu_src1, cur_b);
            chk("no_accept_in_issue", {31'd0, req_ready}, 32'd0);
        end
    end

    // ---------------- reference model ----------------
    function automatic int m_lat(input logic [3:0] op, input bit nf);
        if (op > 4'd12) return 1;
        if (nf)         return 16;
        case (op)
            4'd0, 4'd1, 4'd2: return 5;
            4'd3:             return 12;
            4'd4:             return 10;
            default:          return 2;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns at the falling edge that
    // follows the accepting rising edge.
    task automatic start_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [31:0] an, input bit nf);
        cur_op    = op;
        cur_a     = a;
        cur_b     = b;
        ans       = an;
        never_fin = nf;
        req_op    = op;
        req_src0  = a;
        req_src1  = b;
        req_rd    = rd;
        req_valid = 1'b1;
        #1;
        chk("req_ready_at_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_op     = 4'($urandom_range(0, 15));
        req_src0   = $urandom;
        req_src1   = $urandom;
        req_rd     = 5'($urandom_range(0, 31));
    endtask

    // Measures latency in rising edges from accept, checks the fields,
    // then holds resp_ready low for 'hold' cycles checking stability.
    task automatic check_resp(input int elat, input logic [31:0] eres, input logic [4:0] erd,
                              input bit eint, input bit eerr, input int hold);
        int lat;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_latency", lat, elat);
        chk("resp_result", resp_result, eres);
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, erd});
        chk("resp_int", {31'd0, resp_int}, {31'd0, eint});
        chk("resp_err", {31'd0, resp_err}, {31'd0, eerr});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_result", resp_result, eres);
            chk("hold_rd", {27'd0, resp_rd}, {27'd0, erd});
            chk("hold_int_err", {30'd0, resp_int, resp_err}, {30'd0, eint, eerr});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        #1;
        chk("consume_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("idle_after_consume", {31'd0, resp_valid}, 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] ans;
        bit          nf;
        int          hold;
        int          lat;
        logic [31:0] res;
        bit          ri;
        bit          re;
    } vec_t;

    vec_t tbl[13];

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        tbl[0]  = '{4'd0,  32'h3F800000, 32'h40000000, 5'd3,  32'h40400000, 1'b0, 0, 5,  32'h40400000, 1'b0, 1'b0};
        tbl[1]  = '{4'd3,  32'h40800000, 32'h40000000, 5'd4,  32'h40000000, 1'b0, 3, 12, 32'h40000000, 1'b0, 1'b0};
        tbl[2]  = '{4'd13, 32'h11111111, 32'h22222222, 5'd5,  32'hDEADBEEF, 1'b0, 1, 1,  32'h00000000, 1'b0, 1'b1};
        tbl[3]  = '{4'd0,  32'h3F800000, 32'h3F800000, 5'd6,  32'h12345678, 1'b1, 0, 16, 32'h00000000, 1'b0, 1'b1};
        tbl[4]  = '{4'd5,  32'h3F800000, 32'hBF800000, 5'd1,  32'hBF800000, 1'b0, 0, 2,  32'hBF800000, 1'b0, 1'b0};
        tbl[5]  = '{4'd4,  32'h40800000, 32'h00000000, 5'd2,  32'h40000000, 1'b0, 2, 10, 32'h40000000, 1'b0, 1'b0};
        tbl[6]  = '{4'd2,  32'h40000000, 32'h40400000, 5'd8,  32'h40C00000, 1'b0, 2, 5,  32'h40C00000, 1'b0, 1'b0};
        tbl[7]  = '{4'd11, 32'h40A00000, 32'h00000000, 5'd9,  32'h00000005, 1'b0, 0, 2,  32'h00000005, 1'b1, 1'b0};
        tbl[8]  = '{4'd8,  32'h3F800000, 32'h3F800000, 5'd10, 32'h00000001, 1'b0, 0, 2,  32'h00000001, 1'b1, 1'b0};
        tbl[9]  = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'hCAFEF00D, 1'b0, 0, 1,  32'h00000000, 1'b0, 1'b1};
        tbl[10] = '{4'd12, 32'h00000005, 32'h00000000, 5'd11, 32'h40A00000, 1'b0, 0, 2,  32'h40A00000, 1'b0, 1'b0};
        tbl[11] = '{4'd9,  32'h40000000, 32'h3F800000, 5'd12, 32'h00000000, 1'b0, 1, 2,  32'h00000000, 1'b1, 1'b0};
        tbl[12] = '{4'd1,  32'h40400000, 32'h3F800000, 5'd13, 32'h40000000, 1'b0, 0, 5,  32'h40000000, 1'b0, 1'b0};

        // reset block
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_op     = 4'd0;
        req_src0   = 32'd0;
        req_src1   = 32'd0;
        req_rd     = 5'd0;
        cur_op     = 4'd0;
        cur_a      = 32'd0;
        cur_b      = 32'd0;
        ans        = 32'd0;
        never_fin  = 1'b0;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_rd_int_err", {25'd0, resp_rd, resp_int, resp_err}, 32'd0);
        chk("rst_fpu_op", {28'd0, fpu_op}, 32'hF);
        chk("rst_fpu_src", fpu_src0 | fpu_src1, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 13; i++) begin
            start_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].ans, tbl[i].nf);
            check_resp(tbl[i].lat, tbl[i].res, tbl[i].rd, tbl[i].ri, tbl[i].re, tbl[i].hold);
            consume();
        end

        // back-to-back: flt, then fsgnjx accepted on the consume edge
        start_req(4'd10, 32'h3F800000, 32'h40000000, 5'd7, 32'h00000001, 1'b0);
        check_resp(2, 32'h00000001, 5'd7, 1'b1, 1'b0, 0);
        resp_ready = 1'b1;
        start_req(4'd7, 32'hBF800000, 32'hBF800000, 5'd14, 32'h3F800000, 1'b0);
        check_resp(2, 32'h3F800000, 5'd14, 1'b0, 1'b0, 0);
        // illegal op back-to-back: RESP stays in RESP with the new tag
        resp_ready = 1'b1;
        start_req(4'd14, 32'd0, 32'd0, 5'd21, 32'h55555555, 1'b0);
        check_resp(1, 32'd0, 5'd21, 1'b0, 1'b1, 1);
        consume();

        // reset pulsed during fsqrt ISSUE
        start_req(4'd4, 32'h41100000, 32'h00000000, 5'd17, 32'h40400000, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_resp_fields", resp_result | {25'd0, resp_rd, resp_int, resp_err}, 32'd0);
        chk("midrst_fpu_op", {28'd0, fpu_op}, 32'hF);
        chk("midrst_fpu_src", fpu_src0 | fpu_src1, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("no_resp_after_abandon", {31'd0, seen}, 32'd0);
        start_req(4'd5, 32'h40400000, 32'h80000000, 5'd18, 32'hC0400000, 1'b0);
        check_resp(2, 32'hC0400000, 5'd18, 1'b0, 1'b0, 0);
        consume();

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b, an;
            logic [4:0]  rd;
            bit          nf, legal;
            int          hold;
            op    = 4'($urandom_range(0, 15));
            a     = $urandom;
            b     = $urandom;
            an    = $urandom;
            rd    = 5'($urandom_range(0, 31));
            legal = (op <= 4'd12);
            nf    = legal && ($urandom_range(0, 7) == 0);
            hold  = $urandom_range(0, 2);
            if (i > 0) begin
                if ($urandom_range(0, 2) == 0) resp_ready = 1'b1;
                else                           consume();
            end
            start_req(op, a, b, rd, an, nf);
            check_resp(m_lat(op, nf), (!legal || nf) ? 32'd0 : an, rd,
                       legal && (op >= 4'd8) && (op <= 4'd11), !legal || nf, hold);
        end
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
